// File: rtl/ddr5_cmd_issuer_if.sv
// Request/command bundle between the request queue, the DDR5 command issuer
// and the trace stage. The issuer is the slave side; the queue/observer side
// is the master.
interface ddr5_cmd_issuer_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_core;
  logic [1:0]  req_op;
  logic [2:0]  req_bg;
  logic [1:0]  req_ba;
  logic [15:0] req_row;
  logic [9:0]  req_col;

  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [3:0]  cmd_core;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_ba;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        busy;
  logic        done;

  modport master (
    output req_valid, req_core, req_op, req_bg, req_ba, req_row, req_col,
    input  req_ready, cmd_valid, cmd_code, cmd_core, cmd_bg, cmd_ba,
           cmd_row, cmd_col, busy, done
  );

  modport slave (
    input  req_valid, req_core, req_op, req_bg, req_ba, req_row, req_col,
    output req_ready, cmd_valid, cmd_code, cmd_core, cmd_bg, cmd_ba,
           cmd_row, cmd_col, busy, done
  );
endinterface

// File: rtl/ddr5_cmd_issuer.sv
// DDR5 closed-page command issuer. Pops one request, emits ACT0/ACT1,
// RD0/RD1 or WR0/WR1, then PRE on DIMM ticks (every other CPU clock), with
// tRCD / tRTP|tWTP / tRP spacing enforced by a single down-counter.
// Optional: define CMD_TRACE_EN to print every issued command with a cycle stamp.
module ddr5_cmd_issuer #(
  parameter int T_RCD = 39,
  parameter int T_RTP = 18,
  parameter int T_WTP = 78,
  parameter int T_RP  = 39,
  parameter int CNT_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  ddr5_cmd_issuer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, S_ACT0, S_ACT1, S_WAIT_RCD, S_CAS1, S_WAIT_PRE, S_WAIT_RP, DONE
  } state_t;

  localparam logic [2:0] C_ACT0 = 3'd0, C_ACT1 = 3'd1, C_RD0 = 3'd2, C_RD1 = 3'd3,
                         C_WR0  = 3'd4, C_WR1  = 3'd5, C_PRE = 3'd6, C_NOP = 3'd7;

  // Waits are loaded with T-1 so the gated command lands exactly T ticks later.
  localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] LD_RTP = CNT_W'(T_RTP - 1);
  localparam logic [CNT_W-1:0] LD_WTP = CNT_W'(T_WTP - 1);
  localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             phase;
  logic             up;          // first clock out of reset has passed
  logic             wr;          // latched request is a write
  logic             cmd_valid_q, cmd_valid_n;
  logic [2:0]       cmd_code_q, cmd_code_n;
  logic [3:0]       core_q;
  logic [2:0]       bg_q;
  logic [1:0]       ba_q;
  logic [15:0]      row_q;
  logic [9:0]       col_q;

  logic tick, accept, done;

  assign tick   = (phase == 1'b0);
  assign done   = (state == DONE);
  assign accept = bus.req_valid && bus.req_ready;

  assign bus.req_ready = up && (state == IDLE) && !done;
  assign bus.busy      = (state != IDLE) && (state != DONE);
  assign bus.done      = done;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_code  = cmd_code_q;
  assign bus.cmd_core  = core_q;
  assign bus.cmd_bg    = bg_q;
  assign bus.cmd_ba    = ba_q;
  assign bus.cmd_row   = row_q;
  assign bus.cmd_col   = col_q;

  // Next-state, counter and command selection; commands only fire on ticks.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cmd_valid_n = 1'b0;
    cmd_code_n  = C_NOP;
    case (state)
      IDLE: if (accept) state_n = (bus.req_op == 2'd3) ? DONE : S_ACT0;
      S_ACT0: if (tick) begin
        cmd_valid_n = 1'b1;
        cmd_code_n  = C_ACT0;
        state_n     = S_ACT1;
      end
      S_ACT1: if (tick) begin
        cmd_valid_n = 1'b1;
        cmd_code_n  = C_ACT1;
        cnt_n       = LD_RCD;
        state_n     = S_WAIT_RCD;
      end
      S_WAIT_RCD: if (tick) begin
        if (cnt == '0) begin
          cmd_valid_n = 1'b1;
          cmd_code_n  = wr ? C_WR0 : C_RD0;
          state_n     = S_CAS1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_CAS1: if (tick) begin
        cmd_valid_n = 1'b1;
        cmd_code_n  = wr ? C_WR1 : C_RD1;
        cnt_n       = wr ? LD_WTP : LD_RTP;
        state_n     = S_WAIT_PRE;
      end
      S_WAIT_PRE: if (tick) begin
        if (cnt == '0) begin
          cmd_valid_n = 1'b1;
          cmd_code_n  = C_PRE;
          cnt_n       = LD_RP;
          state_n     = S_WAIT_RP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_WAIT_RP: if (tick) begin
        if (cnt == '0) state_n = DONE;
        else           cnt_n   = cnt - 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM state, tick phase, timing counter and registered command outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      phase       <= 1'b0;
      up          <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= C_NOP;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      phase       <= ~phase;
      up          <= 1'b1;
      cmd_valid_q <= cmd_valid_n;
      cmd_code_q  <= cmd_code_n;
    end
  end

  // Request fields: latched at accept, held for the request, zero in IDLE.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr     <= 1'b0;
      core_q <= '0;
      bg_q   <= '0;
      ba_q   <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else if (accept) begin
      wr     <= (bus.req_op == 2'd1);
      core_q <= bus.req_core;
      bg_q   <= bus.req_bg;
      ba_q   <= bus.req_ba;
      row_q  <= bus.req_row;
      col_q  <= bus.req_col;
    end else if (state_n == IDLE) begin
      wr     <= 1'b0;
      core_q <= '0;
      bg_q   <= '0;
      ba_q   <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end
  end

`ifdef CMD_TRACE_EN
  logic [31:0] cycle;

  // Free-running clock stamp for the trace.
  always_ff @(posedge clock) begin
    if (!reset_n) cycle <= '0;
    else          cycle <= cycle + 32'd1;
  end

  // Print each issued command at the end of the clock it was valid in.
  always_ff @(posedge clock) begin
    if (cmd_valid_q) begin
      case (cmd_code_q)
        C_ACT0:  $display("%0d %0d ACT0 %0h %0h %0h", cycle, core_q, bg_q, ba_q, row_q);
        C_ACT1:  $display("%0d %0d ACT1 %0h %0h %0h", cycle, core_q, bg_q, ba_q, row_q);
        C_RD0:   $display("%0d %0d RD0 %0h %0h %0h", cycle, core_q, bg_q, ba_q, col_q);
        C_RD1:   $display("%0d %0d RD1 %0h %0h %0h", cycle, core_q, bg_q, ba_q, col_q);
        C_WR0:   $display("%0d %0d WR0 %0h %0h %0h", cycle, core_q, bg_q, ba_q, col_q);
        C_WR1:   $display("%0d %0d WR1 %0h %0h %0h", cycle, core_q, bg_q, ba_q, col_q);
        C_PRE:   $display("%0d %0d PRE %0h %0h", cycle, core_q, bg_q, ba_q);
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_ddr5_cmd_issuer.sv
// Bench for ddr5_cmd_issuer: table of requests with expected command timing,
// scoreboard queues filled at accept time and drained by an output monitor.
module tb_ddr5_cmd_issuer;
  localparam int TB_RCD = 2, TB_RTP = 3, TB_WTP = 5, TB_RP = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ddr5_cmd_issuer_if bus();

  ddr5_cmd_issuer #(
    .T_RCD(TB_RCD), .T_RTP(TB_RTP), .T_WTP(TB_WTP), .T_RP(TB_RP), .CNT_W(8)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  core;
    logic [2:0]  bg;
    logic [1:0]  ba;
    logic [15:0] row;
    logic [9:0]  col;
    int          ncmd;      // expected command pulses
    logic [2:0]  cas;       // first CAS code
    int          pre_off;   // PRE edge relative to ACT0 edge
    int          done_off;  // done edge relative to ACT0 edge
  } vec_t;

  typedef struct {
    int          edge_n;
    logic [2:0]  code;
    logic [34:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   checks = 0, errors = 0;
  int   rel = -1;          // posedges since reset release, 0 = first
  int   pulses = 0;
  bit   busy_seen = 1'b0;
  bit   done_prev = 1'b0;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, rel);
    end
  endtask

  // Output monitor: samples 1 time unit after every rising edge.
  initial begin
    exp_t e;
    int   d;
    forever begin
      @(posedge clock);
      if (!reset_n) rel = -1;
      else          rel = rel + 1;
      #1;
      if (!reset_n) begin
        check("rst_ready", bus.req_ready, 0);
        check("rst_cmd_valid", bus.cmd_valid, 0);
        check("rst_cmd_code", bus.cmd_code, 7);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_addr", {bus.cmd_core, bus.cmd_bg, bus.cmd_ba, bus.cmd_row, bus.cmd_col}, 0);
        done_prev = 1'b0;
      end else begin
        if (rel == 0) check("ready_after_rst", bus.req_ready, 1);
        if (bus.cmd_valid) begin
          pulses++;
          if (exp_q.size() == 0) begin
            check("unexpected_cmd", bus.cmd_code, 7);
          end else begin
            e = exp_q.pop_front();
            check("cmd_code", bus.cmd_code, e.code);
            check("cmd_edge", rel, e.edge_n);
            check("cmd_addr", {bus.cmd_core, bus.cmd_bg, bus.cmd_ba, bus.cmd_row, bus.cmd_col}, e.addr);
          end
        end else if (bus.cmd_code !== 3'd7) begin
          check("nop_code", bus.cmd_code, 7);
        end
        if (bus.busy) busy_seen = 1'b1;
        if (bus.done) begin
          if (done_q.size() == 0) begin
            check("unexpected_done", bus.done, 0);
          end else begin
            d = done_q.pop_front();
            check("done_edge", rel, d);
            check("done_busy", bus.busy, 0);
            check("done_ready", bus.req_ready, 0);
          end
        end
        if (done_prev) check("ready_after_done", bus.req_ready, 1);
        done_prev = bus.done;
      end
    end
  end

  // Drive a request, wait for ready, push its expected commands.
  task automatic send(input vec_t v, input bit hold);
    int a, t0;
    bit got = 1'b0;
    exp_t e;
    logic [34:0] addr;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_op    = v.op;
    bus.req_core  = v.core;
    bus.req_bg    = v.bg;
    bus.req_ba    = v.ba;
    bus.req_row   = v.row;
    bus.req_col   = v.col;
    for (int k = 0; k < 400; k++) begin
      if (bus.req_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("accept", got, 1);
    if (!got) begin
      bus.req_valid = 1'b0;
      return;
    end
    a = rel + 1;
    addr = {v.core, v.bg, v.ba, v.row, v.col};
    if (v.ncmd == 0) begin
      done_q.push_back(a);
    end else begin
      t0 = (a % 2 == 0) ? a + 2 : a + 1;
      e.addr = addr;
      e.edge_n = t0;                  e.code = 3'd0;        exp_q.push_back(e);
      e.edge_n = t0 + 2;              e.code = 3'd1;        exp_q.push_back(e);
      e.edge_n = t0 + 2 + 2 * TB_RCD; e.code = v.cas;       exp_q.push_back(e);
      e.edge_n = t0 + 4 + 2 * TB_RCD; e.code = v.cas + 3'd1; exp_q.push_back(e);
      e.edge_n = t0 + v.pre_off;      e.code = 3'd6;        exp_q.push_back(e);
      done_q.push_back(t0 + v.done_off);
    end
    @(negedge clock);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("drain", exp_q.size() + done_q.size(), 0);
    repeat (4) @(negedge clock);
  endtask

  initial begin
    int snap;
    vecs[0] = '{2'd0, 4'd1, 3'd3, 2'd1, 16'h1A2B, 10'h03F, 5, 3'd2, 14, 18};
    vecs[1] = '{2'd1, 4'd2, 3'd3, 2'd1, 16'h1A2B, 10'h03F, 5, 3'd4, 18, 22};
    vecs[2] = '{2'd2, 4'd5, 3'd7, 2'd3, 16'hFFFF, 10'h3FF, 5, 3'd2, 14, 18};
    vecs[3] = '{2'd3, 4'd9, 3'd4, 2'd2, 16'h0F0F, 10'h155, 0, 3'd7, 0, 0};
    vecs[4] = '{2'd1, 4'd0, 3'd0, 2'd0, 16'h0000, 10'h000, 5, 3'd4, 18, 22};

    // Reset held 4 clocks with a request pending.
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd0;
    bus.req_core  = 4'd7;
    bus.req_bg    = 3'd1;
    bus.req_ba    = 2'd1;
    bus.req_row   = 16'h5555;
    bus.req_col   = 10'h2AA;
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clock);

    // Table of single requests.
    foreach (vecs[i]) begin
      snap = pulses;
      busy_seen = 1'b0;
      send(vecs[i], 1'b0);
      drain(200);
      check("pulse_count", pulses - snap, vecs[i].ncmd);
      if (vecs[i].ncmd == 0) check("reserved_busy", busy_seen, 0);
    end

    // Back-to-back reads with valid held high.
    snap = pulses;
    send(vecs[0], 1'b1);
    send(vecs[2], 1'b0);
    drain(400);
    check("b2b_pulses", pulses - snap, 10);

    // Reset one clock after RD0 aborts the request.
    send(vecs[0], 1'b0);
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 2) break;
      @(negedge clock);
    end
    check("wait_rd0", exp_q.size(), 2);
    reset_n = 1'b0;
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    snap = pulses;
    repeat (6) @(negedge clock);
    check("no_cmd_after_abort", pulses - snap, 0);
    send(vecs[1], 1'b0);
    drain(200);
    check("post_abort_pulses", pulses - snap, 5);

    check("leftover", exp_q.size() + done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ddr5_cmd_issuer.md
Name: ddr5_cmd_issuer

Overview:
- Consumer end of the memory request queue. It pops one mapped request at a time over a valid/ready handshake.
- Each request is expanded into a closed-page DDR5 command sequence: ACT0, ACT1, then RD0/RD1 or WR0/WR1, then PRE.
- Commands are issued on DIMM-clock ticks, where one DIMM tick equals two CPU clocks, and inter-command timing is enforced.
- Output feeds the command trace/output stage.

Parameters:
- T_RCD, 39: DIMM ticks from ACT1 to RD0/WR0.
- T_RTP, 18: DIMM ticks from RD1 to PRE.
- T_WTP, 78: DIMM ticks from WR1 to PRE (CWL + BL/2 + tWR, pre-summed).
- T_RP, 39: DIMM ticks from PRE to request completion.
- CNT_W, 8: width of the timing down-counter. It must hold max(T_*).

Ports:
- clock, in, 1: CPU clock.
- reset_n, in, 1: synchronous active-low reset.
- req_valid, in, 1: a queue head request is present.
- req_ready, out, 1: issuer can accept a request.
- req_core, in, 4: requesting core id.
- req_op, in, 2: 0 = data read, 1 = data write, 2 = instruction fetch (treated as read), 3 = reserved.
- req_bg, in, 3: bank group.
- req_ba, in, 2: bank.
- req_row, in, 16: row.
- req_col, in, 10: column.
- cmd_valid, out, 1: command valid for this clock.
- cmd_code, out, 3: 0 = ACT0, 1 = ACT1, 2 = RD0, 3 = RD1, 4 = WR0, 5 = WR1, 6 = PRE, 7 = NOP.
- cmd_core, out, 4: core of the active request.
- cmd_bg, out, 3: bank group of the active request.
- cmd_ba, out, 2: bank of the active request.
- cmd_row, out, 16: row of the active request.
- cmd_col, out, 10: column of the active request.
- busy, out, 1: a request is in flight.
- done, out, 1: one-clock pulse when the request retires.

Behaviour:
- Reset (reset_n low at a clock edge):
  - State goes to IDLE, phase to 0, counter to 0.
  - Outputs: req_ready = 0, cmd_valid = 0, cmd_code = 7, busy = 0, done = 0, all address/core outputs = 0.
  - req_ready rises on the first clock after reset deasserts.
- Phase:
  - phase toggles every clock after reset.
  - A DIMM tick is a clock with phase == 0.
  - cmd_valid may be 1 only on tick clocks, and only for that single clock. At all other times cmd_code = 7.
- Handshake:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - req_* fields are latched at acceptance.
  - req_ready = (state == IDLE) && !done.
  - The producer holds fields stable while valid is high and ready is low.
  - req_op == 3 is accepted and retired with done only: no commands are issued, and done pulses on the clock after acceptance.
- States and transitions (every transition except IDLE and DONE waits for a tick):
  - IDLE: on accept, go to S_ACT0. busy = 1 from the clock after accept.
  - S_ACT0: at the next tick, issue ACT0 (row), then go to S_ACT1.
  - S_ACT1: at the next tick, issue ACT1 (row), load counter = T_RCD-1, go to S_WAIT_RCD.
  - S_WAIT_RCD: decrement each tick. Wait states issue no command; cmd_code stays 7.
    - When counter == 0 at a tick, issue RD0 (op 0/2) or WR0 (op 1), then go to S_CAS1.
    - Net effect: the first CAS command lands exactly T_RCD ticks after ACT1.
  - S_CAS1: at the next tick, issue RD1 or WR1. Load counter = T_RTP-1 (read) or T_WTP-1 (write). Go to S_WAIT_PRE.
  - S_WAIT_PRE: when counter == 0 at a tick, issue PRE, load counter = T_RP-1, go to S_WAIT_RP.
  - S_WAIT_RP: when counter == 0 at a tick, go to DONE.
  - DONE: done = 1 and busy = 0 for one clock, then go to IDLE. req_ready rises on the following clock.
- Back-to-back requests: minimum one idle clock between done and the next accept. No overlap between requests.
- Boundary conditions:
  - A T_* value of 0 is illegal.
  - Behaviour for T_* = 1 is defined: a wait of 1 means the next tick.
  - Counter arithmetic is unsigned. The counter never wraps; it holds at 0 outside wait states.
  - req_valid dropping while ready is low is ignored.
  - A reset during any state aborts immediately. No PRE is issued, and the outputs take their reset values on that edge.
- Address outputs:
  - cmd_row is meaningful for ACT0/ACT1; cmd_col for RD*/WR*.
  - All address fields are held for the whole request and cleared to 0 in IDLE.

Optional Feature:
- CMD_TRACE_EN defined: on each clock with cmd_valid, the block executes $display("%0d %0d <CMD> %0h %0h %0h", cycle, core, bg, ba, row-or-col).
  - cycle is a free-running 32-bit clock counter (reset to 0).
  - <CMD> is the mnemonic. PRE prints bg and ba only.
- Undefined: no counter, no $display. Synthesizable logic is identical.

Test Plan:
- Use T_RCD=2, T_RTP=3, T_WTP=5, T_RP=2 in all tests.
- Reset check: hold reset_n=0 for 4 clocks with req_valid=1 → req_ready=0, cmd_valid=0, cmd_code=7 throughout. req_ready=1 on the first clock after release.
- Read request accepted at clock 2 (op=0, bg=3, ba=1, row=16'h1A2B, col=10'h3F) → commands:
  - ACT0 at 4, ACT1 at 6
  - RD0 at 10, RD1 at 12
  - PRE at 18
  - done at 22; req_ready=1 at 23
- Write request, same timing start (op=1) → ACT0 4, ACT1 6, WR0 10, WR1 12, PRE 22, done 26.
- Back-to-back: req_valid held high with two queued reads → second ACT0 no earlier than 2 clocks after the first done. Exactly 10 cmd_valid pulses total.
- Reset mid-operation: assert reset_n=0 one clock after RD0 → no RD1/PRE is issued. State returns to IDLE, and a subsequent request runs a complete normal sequence.
- Reserved op=3 → zero cmd_valid pulses. done pulses on the clock after acceptance; busy stays 0.
